// File: rtl/instr_queue_pkg.sv
// Shared types for the fetch-to-decode instruction queue.
// fetch_data_t is the fetch stage's per-slot record; slot [1] of a pair is the older one.
package instr_queue_pkg;

    localparam int unsigned IQ_DEPTH = 16;

    typedef logic [$clog2(IQ_DEPTH)-1:0] iq_ptr_t;
    typedef logic [$clog2(IQ_DEPTH):0]   iq_cnt_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_data_t;

endpackage

// File: rtl/instr_queue_storage.sv
// Unreset register array for the instruction queue: two write ports, two read ports.
// Reads return raw entries; validity masking is the caller's job.
module instr_queue_storage
    import instr_queue_pkg::*;
#(
    parameter int unsigned Depth = IQ_DEPTH
) (
    input  logic                     clk_i,
    input  logic                     we_a_i,
    input  logic [$clog2(Depth)-1:0] waddr_a_i,
    input  fetch_data_t              wdata_a_i,
    input  logic                     we_b_i,
    input  logic [$clog2(Depth)-1:0] waddr_b_i,
    input  fetch_data_t              wdata_b_i,
    input  logic [$clog2(Depth)-1:0] raddr_a_i,
    output fetch_data_t              rdata_a_o,
    input  logic [$clog2(Depth)-1:0] raddr_b_i,
    output fetch_data_t              rdata_b_o
);

    fetch_data_t mem_q [Depth];

    // Port addresses never collide: b always targets the entry after a.
    always_ff @(posedge clk_i) begin
        if (we_a_i) mem_q[waddr_a_i] <= wdata_a_i;
        if (we_b_i) mem_q[waddr_b_i] <= wdata_b_i;
    end

    assign rdata_a_o = mem_q[raddr_a_i];
    assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/instr_queue.sv
// Dual-issue instruction queue between fetch and decode: compacts fetched pairs into a
// circular buffer and presents the two oldest entries, with a single-cycle flush.
module instr_queue
    import instr_queue_pkg::*;
#(
    parameter int unsigned DEPTH = IQ_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  fetch_data_t [1:0] dataF1,
    output logic              full,
    input  logic              flush,
    input  logic [1:0]        pop_num,
    output fetch_data_t [1:0] dataF2
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
    logic [PtrW-1:0] head_p1, tail_p1;
    logic [CntW-1:0] count_q, count_d;

    logic        we_a, we_b;
    fetch_data_t wdata_a;
    logic [1:0]  push_cnt, avail, pop_eff;
    fetch_data_t rdata_a, rdata_b;

    assign full    = count_q > CntW'(DEPTH - 2);
    assign head_p1 = head_q + PtrW'(1);
    assign tail_p1 = tail_q + PtrW'(1);

    always_comb begin
        we_a     = !full && !flush && (dataF1[1].valid || dataF1[0].valid);
        we_b     = !full && !flush && dataF1[1].valid && dataF1[0].valid;
        // A lone younger slot (unaligned fetch start) goes to the tail like an older one.
        wdata_a  = dataF1[1].valid ? dataF1[1] : dataF1[0];
        push_cnt = 2'(we_a) + 2'(we_b);

        avail    = (count_q >= CntW'(2)) ? 2'd2 : count_q[1:0];
        pop_eff  = (pop_num > avail) ? avail : pop_num;

        head_d   = head_q + PtrW'(pop_eff);
        tail_d   = tail_q + PtrW'(push_cnt);
        count_d  = count_q + CntW'(push_cnt) - CntW'(pop_eff);
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    instr_queue_storage #(
        .Depth (DEPTH)
    ) u_storage (
        .clk_i     (clk),
        .we_a_i    (we_a),
        .waddr_a_i (tail_q),
        .wdata_a_i (wdata_a),
        .we_b_i    (we_b),
        .waddr_b_i (tail_p1),
        .wdata_b_i (dataF1[0]),
        .raddr_a_i (head_q),
        .rdata_a_o (rdata_a),
        .raddr_b_i (head_p1),
        .rdata_b_o (rdata_b)
    );

    always_comb begin
        dataF2[1] = (count_q != '0)         ? rdata_a : '0;
        dataF2[0] = (count_q >= CntW'(2))   ? rdata_b : '0;
    end

endmodule
